// File: rtl/mmio_fifo_pkg.sv
// Shared register map, status/control bit positions and status word packing.
package mmio_fifo_pkg;

  localparam logic [1:0]  DATA_OFS  = 2'd0;
  localparam logic [1:0]  STAT_OFS  = 2'd2;
  localparam int unsigned CH_STRIDE = 4;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_UNF     = 3;
  localparam int unsigned ST_CNT_LSB = 16;

  localparam int unsigned CTL_CLR   = 0;
  localparam int unsigned CTL_FLUSH = 1;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STAT
  } reg_kind_e;

  function automatic logic [63:0] status_word(input logic [15:0] cnt, input logic unf,
                                              input logic ovf, input logic full,
                                              input logic empty);
    logic [63:0] s;
    s = '0;
    s[ST_CNT_LSB +: 16] = cnt;
    s[ST_UNF]   = unf;
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/mmio_fifo_bank_chan.sv
// One FIFO channel: storage, wrapping pointers, occupancy count and sticky flags.
module fifo_chan #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clr,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Both acceptance decisions use the state before this edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; contents are never reset, only made unreachable by count.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, count and sticky flags; flush overrides a concurrent pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
        else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
      end
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (push && full)  ovf <= 1'b1;
      if (pop && empty)  unf <= 1'b1;
    end
  end

endmodule

// File: rtl/mmio_fifo_bank.sv
// Bank of independent MMIO-mapped FIFO channels with a 1-cycle read response.
module mmio_fifo_bank
  import mmio_fifo_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 8,
  parameter int          NUM_CH    = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        hit
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [15:0]       off;
  logic [2:0]        ch;
  reg_kind_e         kind;
  logic [63:0]       rd_word;

  logic [DATA_W-1:0] ch_head  [NUM_CH];
  logic [CNT_W-1:0]  ch_count [NUM_CH];
  logic              ch_full  [NUM_CH];
  logic              ch_empty [NUM_CH];
  logic              ch_ovf   [NUM_CH];
  logic              ch_unf   [NUM_CH];

  // Address decode: offset from base selects channel and register kind.
  always_comb begin
    off  = mmio_addr - BASE_ADDR;
    ch   = off[4:2];
    kind = REG_NONE;
    if (off < 16'(CH_STRIDE * NUM_CH)) begin
      if (off[1:0] == DATA_OFS)      kind = REG_DATA;
      else if (off[1:0] == STAT_OFS) kind = REG_STAT;
    end
  end

  assign hit = (kind != REG_NONE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = (ch == 3'(g));

    fifo_chan #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .push     (mmio_wr_valid && kind == REG_DATA && sel),
      .push_data(mmio_wr_data[DATA_W-1:0]),
      .pop      (mmio_rd_valid && kind == REG_DATA && sel),
      .clr      (mmio_wr_valid && kind == REG_STAT && sel && mmio_wr_data[CTL_CLR]),
      .flush    (mmio_wr_valid && kind == REG_STAT && sel && mmio_wr_data[CTL_FLUSH]),
      .head     (ch_head[g]),
      .count    (ch_count[g]),
      .full     (ch_full[g]),
      .empty    (ch_empty[g]),
      .ovf      (ch_ovf[g]),
      .unf      (ch_unf[g])
    );
  end

  // Read data mux from pre-edge channel state; empty data reads yield zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch == 3'(c)) begin
        if (kind == REG_DATA && !ch_empty[c]) begin
          rd_word = 64'(ch_head[c]);
        end else if (kind == REG_STAT) begin
          rd_word = status_word(16'(ch_count[c]), ch_unf[c], ch_ovf[c],
                                ch_full[c], ch_empty[c]);
        end
      end
    end
  end

  // Response register: one pulse per read, suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Bench for mmio_fifo_bank: queue-based channel model, per-cycle compare, directed literals.
module tb_mmio_fifo_bank;

  localparam int          NUM_CH = 4;
  localparam int          DEPTH  = 8;
  localparam logic [15:0] BASE   = 16'h0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        hit;

  int checks = 0;
  int failures = 0;

  mmio_fifo_bank #(
    .DATA_W   (64),
    .DEPTH    (DEPTH),
    .NUM_CH   (NUM_CH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr    (mmio_addr),
    .mmio_tid     (mmio_tid),
    .mmio_wr_data (mmio_wr_data),
    .rsp_valid    (rsp_valid),
    .rsp_tid      (rsp_tid),
    .rsp_data     (rsp_data),
    .hit          (hit)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus sticky flags.
  logic [63:0] mq [NUM_CH][$];
  logic        m_ovf [NUM_CH];
  logic        m_unf [NUM_CH];
  logic        exp_valid = 1'b0;
  logic [8:0]  exp_tid = '0;
  logic [63:0] exp_data = '0;
  logic        model_live = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 none, 1 data register, 2 status register
  function automatic void decode(input logic [15:0] a, output int kind, output int c);
    kind = 0;
    c = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (a == BASE + 16'(4 * i))     begin kind = 1; c = i; end
      if (a == BASE + 16'(4 * i + 2)) begin kind = 2; c = i; end
    end
  endfunction

  function automatic logic [63:0] m_status(input int c);
    int n;
    n = mq[c].size();
    return {32'b0, 16'(n), 12'b0, m_unf[c], m_ovf[c], (n == DEPTH), (n == 0)};
  endfunction

  // Model advances at each rising edge from the inputs held since the last drive.
  always @(posedge clk) begin
    int kind, c, n;
    model_live = 1'b1;
    decode(mmio_addr, kind, c);
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end
      exp_valid = 1'b0;
      exp_tid   = '0;
      exp_data  = '0;
    end else begin
      exp_valid = mmio_rd_valid;
      if (mmio_rd_valid) begin
        exp_tid = mmio_tid;
        if (kind == 1)      exp_data = (mq[c].size() != 0) ? mq[c][0] : 64'h0;
        else if (kind == 2) exp_data = m_status(c);
        else                exp_data = 64'h0;
      end
      if (kind == 1) begin
        n = mq[c].size();
        if (mmio_rd_valid) begin
          if (n == 0) m_unf[c] = 1'b1;
          else void'(mq[c].pop_front());
        end
        if (mmio_wr_valid) begin
          if (n == DEPTH) m_ovf[c] = 1'b1;
          else mq[c].push_back(mmio_wr_data);
        end
      end else if (kind == 2 && mmio_wr_valid) begin
        if (mmio_wr_data[0]) begin
          m_ovf[c] = 1'b0;
          m_unf[c] = 1'b0;
        end
        if (mmio_wr_data[1]) mq[c].delete();
      end
    end
  end

  // Compare process: response against model every cycle, hit against decode of current address.
  always @(negedge clk) begin
    int kind, c;
    if (model_live) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("rsp_tid", 64'(rsp_tid), 64'(exp_tid));
        chk("rsp_data", rsp_data, exp_data);
      end
      decode(mmio_addr, kind, c);
      chk("hit", 64'(hit), 64'(kind != 0));
    end
  end

  // Inputs change 2 time units after a rising edge and are held for the next one.
  task automatic cycle(input logic r, input logic wv, input logic rv, input logic [15:0] a,
                       input logic [8:0] t, input logic [63:0] d);
    @(posedge clk);
    #2;
    rst           = r;
    mmio_wr_valid = wv;
    mmio_rd_valid = rv;
    mmio_addr     = a;
    mmio_tid      = t;
    mmio_wr_data  = d;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 9'h0, 64'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    cycle(1'b0, 1'b1, 1'b0, a, 9'h0, d);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [8:0] t,
                        input logic [63:0] exp);
    cycle(1'b0, 1'b0, 1'b1, a, t, 64'h0);
    idle();
    chk({name, "_valid"}, 64'(rsp_valid), 64'h1);
    chk({name, "_tid"}, 64'(rsp_tid), 64'(t));
    chk(name, rsp_data, exp);
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    int          sel;
    int          c;

    cycle(1'b1, 1'b0, 1'b0, 16'h0, 9'h0, 64'h0);
    cycle(1'b1, 1'b1, 1'b1, BASE, 9'h0, 64'h0);
    idle();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_tid", 64'(rsp_tid), 64'h0);
    chk("reset_rsp_data", rsp_data, 64'h0);

    rd_chk("ch0_status_after_reset", BASE + 16'd2, 9'h1A5, 64'h1);

    wr(BASE, 64'hA);
    wr(BASE, 64'hB);
    wr(BASE, 64'hC);
    rd_chk("ch0_pop0", BASE, 9'h001, 64'hA);
    rd_chk("ch0_pop1", BASE, 9'h002, 64'hB);
    rd_chk("ch0_pop2", BASE, 9'h003, 64'hC);
    rd_chk("ch0_pop_empty", BASE, 9'h004, 64'h0);
    rd_chk("ch0_status_underflow", BASE + 16'd2, 9'h005, 64'h9);

    for (int i = 0; i < 9; i++) wr(BASE + 16'd4, 64'(100 + i));
    rd_chk("ch1_status_overflow", BASE + 16'd6, 9'h010, 64'h0000_0000_0008_0006);
    wr(BASE + 16'd6, 64'h1);
    rd_chk("ch1_status_cleared", BASE + 16'd6, 9'h011, 64'h0000_0000_0008_0002);

    for (int i = 0; i < 5; i++) wr(BASE + 16'd8, 64'(200 + i));
    wr(BASE + 16'd10, 64'h2);
    rd_chk("ch2_status_flushed", BASE + 16'd10, 9'h020, 64'h1);
    rd_chk("ch0_status_isolated", BASE + 16'd2, 9'h021, 64'h9);
    rd_chk("ch1_status_isolated", BASE + 16'd6, 9'h022, 64'h0000_0000_0008_0002);
    rd_chk("ch3_status_isolated", BASE + 16'd14, 9'h023, 64'h1);
    rd_chk("undecoded_read", BASE + 16'd1, 9'h024, 64'h0);

    wr(BASE + 16'd2, 64'h1);
    wr(BASE, 64'h55);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, BASE, 9'(i), 64'(300 + i));
      idle();
      chk("same_cycle_rw_data", rsp_data, (i == 0) ? 64'h55 : 64'(300 + i - 1));
    end
    rd_chk("ch0_status_after_rw", BASE + 16'd2, 9'h030, 64'h0000_0000_0001_0000);

    wr(BASE + 16'd6, 64'h3);
    for (int i = 0; i < 3; i++) wr(BASE + 16'd4, 64'(400 + i));
    cycle(1'b1, 1'b0, 1'b1, BASE + 16'd4, 9'h040, 64'h0);
    idle();
    chk("reset_kills_read", 64'(rsp_valid), 64'h0);
    for (int i = 0; i < NUM_CH; i++) begin
      rd_chk("status_after_midreset", BASE + 16'(4 * i + 2), 9'(i), 64'h1);
    end

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      c   = $urandom_range(0, NUM_CH - 1);
      d   = {$urandom, $urandom};
      if (sel < 5) a = BASE + 16'(4 * c);
      else if (sel < 8) begin
        a = BASE + 16'(4 * c + 2);
        d[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else a = 16'($urandom);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 1) == 1), a, 9'($urandom), d);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
